// File: rtl/video_pixel_feeder.sv
// rtl/video_pixel_feeder.sv - elastic pixel buffer locking an upstream stream to display timing
// Optional underflow_count output when VIDEO_PIXEL_FEEDER_UNDERFLOW_CNT_EN is defined.
module video_pixel_feeder #(
  parameter int                DATA_W          = 24,
  parameter int                FIFO_DEPTH      = 16,
  parameter logic [DATA_W-1:0] UNDERFLOW_COLOR = '0
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              timing_hsync,
  input  logic              timing_vsync,
  input  logic              timing_den,
  input  logic [13:0]       pixel_x,
  input  logic [13:0]       pixel_y,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              clear_status,
  output logic              video_hsync,
  output logic              video_vsync,
  output logic              video_den,
  output logic [DATA_W-1:0] video_data,
  output logic              underflow,
  output logic              misalign,
  output logic              lock
`ifdef VIDEO_PIXEL_FEEDER_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]       underflow_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE    = 1;
  localparam logic [AW-1:0] PTR_ONE    = 1;

  localparam logic [1:0] ST_SEEK = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]        state, next_state;
  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              empty, full, at_origin;
  logic              push, pop, flush, underflow_evt, misalign_evt;
  logic [DATA_W-1:0] pix;
  logic [DATA_W:0]   head;

  logic              d1_hsync, d1_vsync, d1_den;
  logic [DATA_W-1:0] d1_data;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign at_origin = (pixel_x == 14'd0) && (pixel_y == 14'd0);
  assign head      = mem[rd_ptr];
  assign lock      = (state == ST_RUN);
  assign s_ready   = !reset && ((state == ST_SEEK) || !full);

  always_comb begin
    next_state    = state;
    pop           = 1'b0;
    flush         = 1'b0;
    underflow_evt = 1'b0;
    misalign_evt  = 1'b0;
    pix           = '0;
    push          = s_valid && s_ready && ((state != ST_SEEK) || s_sof);
    if (timing_den) begin
      pix = UNDERFLOW_COLOR;
      case (state)
        ST_WAIT: begin
          if (at_origin && !empty) begin
            pop        = 1'b1;
            pix        = head[DATA_W-1:0];
            next_state = ST_RUN;
          end
        end
        ST_RUN: begin
          if (empty) begin
            underflow_evt = 1'b1;
          end else begin
            pop = 1'b1;
            // A frame start must land exactly on the origin pixel and nowhere else.
            if (head[DATA_W] != at_origin) begin
              misalign_evt = 1'b1;
              flush        = 1'b1;
              next_state   = ST_SEEK;
            end else begin
              pix = head[DATA_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
    if ((state == ST_SEEK) && push) next_state = ST_WAIT;
    if (flush) push = 1'b0;
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) state <= ST_SEEK;
    else       state <= next_state;
  end

  always_ff @(posedge pixel_clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (push) mem[wr_ptr] <= {s_sof, s_data};
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      underflow <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      underflow <= underflow_evt | (underflow & ~clear_status);
      misalign  <= misalign_evt  | (misalign  & ~clear_status);
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      d1_hsync    <= 1'b0;
      d1_vsync    <= 1'b0;
      d1_den      <= 1'b0;
      d1_data     <= '0;
      video_hsync <= 1'b0;
      video_vsync <= 1'b0;
      video_den   <= 1'b0;
      video_data  <= '0;
    end else begin
      d1_hsync    <= timing_hsync;
      d1_vsync    <= timing_vsync;
      d1_den      <= timing_den;
      d1_data     <= pix;
      video_hsync <= d1_hsync;
      video_vsync <= d1_vsync;
      video_den   <= d1_den;
      video_data  <= d1_data;
    end
  end

`ifdef VIDEO_PIXEL_FEEDER_UNDERFLOW_CNT_EN
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      underflow_count <= 16'd0;
    end else if (clear_status) begin
      underflow_count <= underflow_evt ? 16'd1 : 16'd0;
    end else if (underflow_evt && (underflow_count != 16'hFFFF)) begin
      underflow_count <= underflow_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_pixel_feeder.sv
// tb/tb_video_pixel_feeder.sv - directed/random bench for video_pixel_feeder against a queue model
module tb_video_pixel_feeder;

  localparam int          DW = 24;
  localparam logic [23:0] UC = 24'h5A5A5A;
  localparam int          HT = 12;
  localparam int          VT = 6;
  localparam int          FT = HT * VT;

  logic          pixel_clock = 1'b0;
  logic          reset = 1'b1;
  logic          timing_hsync = 1'b0, timing_vsync = 1'b0, timing_den = 1'b0;
  logic [13:0]   pixel_x = '0, pixel_y = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_sof = 1'b0, s_valid = 1'b0;
  logic          s_ready;
  logic          clear_status = 1'b0;
  logic          video_hsync, video_vsync, video_den;
  logic [DW-1:0] video_data;
  logic          underflow, misalign, lock;
`ifdef VIDEO_PIXEL_FEEDER_UNDERFLOW_CNT_EN
  logic [15:0]   underflow_count;
`endif

  video_pixel_feeder #(.DATA_W(DW), .FIFO_DEPTH(16), .UNDERFLOW_COLOR(UC)) dut (
    .pixel_clock(pixel_clock), .reset(reset),
    .timing_hsync(timing_hsync), .timing_vsync(timing_vsync), .timing_den(timing_den),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid), .s_ready(s_ready),
    .clear_status(clear_status),
    .video_hsync(video_hsync), .video_vsync(video_vsync), .video_den(video_den),
    .video_data(video_data),
    .underflow(underflow), .misalign(misalign), .lock(lock)
`ifdef VIDEO_PIXEL_FEEDER_UNDERFLOW_CNT_EN
    , .underflow_count(underflow_count)
`endif
  );

  always #5 pixel_clock = ~pixel_clock;

  int errors = 0;
  int checks = 0;

  // stimulus and reference model state
  int          pos = 48;
  bit          src_en = 1'b0;
  int          gap_pct = 0;
  bit          force_den = 1'b0;
  logic [24:0] src[$];
  logic [23:0] words[$];
  logic [23:0] exp_cap[$];
  logic [23:0] cap[$];
  bit          cap_en = 1'b0;
  bit          saw_not_ready = 1'b0;

  int          mode = 0;            // 0 seeking sof, 1 waiting for origin, 2 locked
  logic [24:0] mq[$];
  bit          m_ufl = 1'b0, m_mis = 1'b0;
  int          m_cnt = 0;
  logic [26:0] p1 = '0, p2 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int hh, vv;
    bit d, hs, vs, exp_rdy, acc, origin, ufl, mis, flush;
    int old_mode;
    logic [23:0] pix;
    logic [24:0] e;
    hh = pos % HT;
    vv = pos / HT;
    if (force_den) begin
      d = 1; hs = 0; vs = 0; pixel_x = 14'd1; pixel_y = 14'd1;
    end else begin
      d  = (hh < 8) && (vv < 4);
      hs = (hh >= 9) && (hh < 11);
      vs = (vv == 5);
      pixel_x = d ? 14'(hh) : 14'd0;
      pixel_y = d ? 14'(vv) : 14'd0;
    end
    timing_den = d; timing_hsync = hs; timing_vsync = vs;
    s_valid = src_en && (src.size() > 0) && ($urandom_range(99) >= gap_pct);
    if (s_valid) begin
      e = src[0];
      s_sof = e[24];
      s_data = e[23:0];
    end else begin
      s_sof = 1'($urandom);
      s_data = 24'($urandom);
    end
    #1;
    exp_rdy = !reset && ((mode == 0) || (mq.size() < 16));
    chk("s_ready", s_ready, exp_rdy);
    if (!s_ready) saw_not_ready = 1'b1;
    acc = s_valid && exp_rdy;
    if (reset) begin
      mode = 0; mq.delete(); m_ufl = 0; m_mis = 0; m_cnt = 0; p1 = '0; p2 = '0;
    end else begin
      old_mode = mode;
      origin = (pixel_x == 0) && (pixel_y == 0);
      pix = '0; ufl = 0; mis = 0; flush = 0;
      if (d) begin
        pix = UC;
        if (old_mode == 1 && origin && mq.size() > 0) begin
          e = mq.pop_front();
          pix = e[23:0];
          mode = 2;
        end else if (old_mode == 2) begin
          if (mq.size() == 0) ufl = 1;
          else begin
            e = mq.pop_front();
            if (e[24] != origin) begin mis = 1; flush = 1; end
            else pix = e[23:0];
          end
        end
      end
      if (acc) begin
        if (old_mode == 0) begin
          if (s_sof) begin mq.push_back({s_sof, s_data}); mode = 1; end
        end else if (!flush) mq.push_back({s_sof, s_data});
      end
      if (flush) begin mq.delete(); mode = 0; end
      m_ufl = ufl | (m_ufl & !clear_status);
      m_mis = mis | (m_mis & !clear_status);
      if (clear_status) m_cnt = ufl ? 1 : 0;
      else if (ufl && m_cnt < 65535) m_cnt++;
      p2 = p1;
      p1 = {hs, vs, d, pix};
    end
    if (acc) void'(src.pop_front());
    pos = (pos + 1) % FT;
    @(posedge pixel_clock);
    #1;
    chk("video_hsync", video_hsync, p2[26]);
    chk("video_vsync", video_vsync, p2[25]);
    chk("video_den",   video_den,   p2[24]);
    chk("video_data",  video_data,  p2[23:0]);
    chk("underflow",   underflow,   m_ufl);
    chk("misalign",    misalign,    m_mis);
    chk("lock",        lock,        mode == 2);
`ifdef VIDEO_PIXEL_FEEDER_UNDERFLOW_CNT_EN
    chk("underflow_count", underflow_count, m_cnt);
`endif
    if (cap_en && video_den) cap.push_back(video_data);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 2 * FT && pos != target; i++) step();
    chk("run_to_position", pos, target);
  endtask

  task automatic make_frame(input int n, input int extra_sof);
    logic [23:0] w;
    words.delete();
    for (int i = 0; i < n; i++) begin
      w = 24'($urandom);
      src.push_back({(i == 0) || (i == extra_sof), w});
      words.push_back(w);
    end
  endtask

  task automatic check_cap(input string tag);
    chk({tag, "_count"}, cap.size(), exp_cap.size());
    for (int i = 0; i < exp_cap.size() && i < cap.size(); i++) chk(tag, cap[i], exp_cap[i]);
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    repeat (2) step();
    chk("reset_video_den", video_den, 0);
    chk("reset_lock", lock, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", s_ready, 1);

    // full frame streamed ahead, FIFO fills and back-pressures
    make_frame(32, -1);
    src_en = 1'b1;
    run_to(0);
    cap.delete(); cap_en = 1'b1;
    step();
    chk("lock_at_origin", lock, 1);
    run_to(48);
    cap_en = 1'b0;
    chk("fifo_backpressure_seen", saw_not_ready, 1);
    exp_cap = words;
    check_cap("frame_in_order");

    // upstream stops after 10 words
    make_frame(10, -1);
    run_to(0);
    cap.delete(); cap_en = 1'b1;
    run_to(44);
    chk("underflow_set", underflow, 1);
    chk("lock_held", lock, 1);
    clear_status = 1'b1; step(); clear_status = 1'b0;
    chk("underflow_cleared", underflow, 0);
    run_to(48);
    cap_en = 1'b0;
    exp_cap = words;
    for (int i = 10; i < 32; i++) exp_cap.push_back(UC);
    check_cap("underflow_frame");

    // stray sof at word 5
    make_frame(32, 5);
    run_to(0);
    repeat (6) step();
    chk("misalign_set", misalign, 1);
    chk("lock_lost", lock, 0);
    chk("ready_after_flush", s_ready, 1);
    clear_status = 1'b1; step(); clear_status = 1'b0;
    chk("misalign_cleared", misalign, 0);
    src.delete();
    run_to(48);

    // random gaps on the upstream side
    gap_pct = 30;
    make_frame(32, -1);
    run_to(0);
    repeat (60) step();
    gap_pct = 0;

    // reset in the middle of a frame
    src.delete();
    make_frame(32, -1);
    run_to(27);
    reset = 1'b1; step(); reset = 1'b0;
    chk("midframe_reset_den", video_den, 0);
    chk("midframe_reset_data", video_data, 0);
    chk("midframe_reset_lock", lock, 0);
    run_to(0);
    cap.delete(); cap_en = 1'b1;
    run_to(48);
    cap_en = 1'b0;
    chk("no_relock_without_sof", lock, 0);
    exp_cap.delete();
    for (int i = 0; i < 32; i++) exp_cap.push_back(UC);
    check_cap("post_reset_frame");

    src.delete();
    make_frame(32, -1);
    run_to(0);
    cap.delete(); cap_en = 1'b1;
    run_to(48);
    cap_en = 1'b0;
    exp_cap = words;
    check_cap("relock_frame");

`ifdef VIDEO_PIXEL_FEEDER_UNDERFLOW_CNT_EN
    force_den = 1'b1;
    clear_status = 1'b1; step(); clear_status = 1'b0;
    chk("count_clear_and_inc", underflow_count, 1);
    repeat (70000) step();
    chk("count_saturated", underflow_count, 16'hFFFF);
    force_den = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
